// File: rtl/post_target_initiator.sv
// Target-side POST port initiator: turns SYNC/OUTPUT/INPUT/CLEAR commands into timed
// testreq pulse groups and samples the box's testack reply on each pulse.
module post_target_initiator #(
    parameter int PWID_CYCLES  = 24,
    parameter int PGAP_CYCLES  = 24,
    parameter int BREAK_CYCLES = 1200,
    parameter int SAMPLE_DELAY = 5
) (
    input  logic       fpga_clock_48mhz,
    input  logic       reset_in_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic       rsp_ok,
    output logic [7:0] rsp_data,
    output logic       testreq,
    input  logic       testack,
    output logic       busy
);
    localparam int MAX_AB  = (PWID_CYCLES > PGAP_CYCLES) ? PWID_CYCLES : PGAP_CYCLES;
    localparam int MAX_CYC = (MAX_AB > BREAK_CYCLES) ? MAX_AB : BREAK_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] T_PWID   = TW'(PWID_CYCLES - 1);
    localparam logic [TW-1:0] T_PGAP   = TW'(PGAP_CYCLES - 1);
    localparam logic [TW-1:0] T_BREAK  = TW'(BREAK_CYCLES - 1);
    localparam logic [TW-1:0] T_SAMPLE = TW'(PWID_CYCLES - SAMPLE_DELAY);

    localparam logic [1:0] OP_SYNC = 2'b00;
    localparam logic [1:0] OP_OUT  = 2'b01;
    localparam logic [1:0] OP_IN   = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [2:0] {IDLE, HIGH, GAP, BREAK, RESP} state_t;

    state_t          state_q;
    logic [TW-1:0]   timer_q;
    logic [3:0]      pulse_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [1:0]      op_q;
    logic [7:0]      data_q;
    logic [7:0]      shift_q;
    logic            data_phase_q;
    logic            ack_s1_q;
    logic            ack_s2_q;
    logic            ack_cap_q;
    logic            testreq_q;
    logic            cmd_ready_q;
    logic            rsp_valid_q;
    logic            rsp_ok_q;
    logic [7:0]      rsp_data_q;

    logic [3:0]      group_len;
    logic            group_last;

    // Pulses in the group currently being sent; OUTPUT data groups encode the bit in the count.
    always_comb begin
        group_len = 4'd4;
        if (data_phase_q) begin
            if (op_q == OP_IN)
                group_len = 4'd8;
            else
                group_len = data_q[7] ? 4'd1 : 4'd2;
        end else begin
            case (op_q)
                OP_OUT:  group_len = 4'd3;
                OP_CLR:  group_len = 4'd12;
                default: group_len = 4'd4;
            endcase
        end
    end

    assign group_last = ((pulse_cnt_q + 4'd1) == group_len);

    always_ff @(posedge fpga_clock_48mhz) begin
        if (!reset_in_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            pulse_cnt_q  <= '0;
            bit_cnt_q    <= '0;
            op_q         <= OP_SYNC;
            data_q       <= '0;
            shift_q      <= '0;
            data_phase_q <= 1'b0;
            ack_s1_q     <= 1'b0;
            ack_s2_q     <= 1'b0;
            ack_cap_q    <= 1'b0;
            testreq_q    <= 1'b0;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_ok_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            ack_s1_q    <= testack;
            ack_s2_q    <= ack_s1_q;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (cmd_valid) begin
                        op_q         <= cmd_op;
                        data_q       <= cmd_data;
                        shift_q      <= '0;
                        data_phase_q <= 1'b0;
                        pulse_cnt_q  <= '0;
                        bit_cnt_q    <= '0;
                        timer_q      <= T_PWID;
                        testreq_q    <= 1'b1;
                        cmd_ready_q  <= 1'b0;
                        state_q      <= HIGH;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                HIGH: begin
                    if (timer_q == T_SAMPLE)
                        ack_cap_q <= ack_s2_q;
                    if (timer_q == '0) begin
                        testreq_q   <= 1'b0;
                        pulse_cnt_q <= pulse_cnt_q + 4'd1;
                        if (data_phase_q && op_q == OP_IN) begin
                            shift_q   <= {shift_q[6:0], ack_cap_q};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        if (!group_last) begin
                            timer_q <= T_PGAP;
                            state_q <= GAP;
                        end else if (!data_phase_q && op_q == OP_IN && ack_cap_q) begin
                            // INPUT data pulses follow the status group after only a gap
                            data_phase_q <= 1'b1;
                            pulse_cnt_q  <= '0;
                            timer_q      <= T_PGAP;
                            state_q      <= GAP;
                        end else begin
                            timer_q <= T_BREAK;
                            state_q <= BREAK;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                GAP: begin
                    if (timer_q == '0) begin
                        testreq_q <= 1'b1;
                        timer_q   <= T_PWID;
                        state_q   <= HIGH;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                BREAK: begin
                    if (timer_q == '0) begin
                        pulse_cnt_q <= '0;
                        if (op_q == OP_OUT && !data_phase_q && ack_cap_q) begin
                            data_phase_q <= 1'b1;
                            testreq_q    <= 1'b1;
                            timer_q      <= T_PWID;
                            state_q      <= HIGH;
                        end else if (op_q == OP_OUT && data_phase_q && bit_cnt_q != 3'd7) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            data_q    <= {data_q[6:0], 1'b0};
                            testreq_q <= 1'b1;
                            timer_q   <= T_PWID;
                            state_q   <= HIGH;
                        end else begin
                            // Failed status leaves ack_cap_q low, so this covers every op
                            bit_cnt_q   <= bit_cnt_q + 3'd1;
                            rsp_ok_q    <= data_phase_q | ack_cap_q;
                            rsp_data_q  <= (op_q == OP_IN && data_phase_q) ? shift_q : 8'h00;
                            rsp_valid_q <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state_q     <= RESP;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    testreq_q   <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign testreq   = testreq_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = ~cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_ok    = rsp_ok_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_post_target_initiator.sv
// Bench for post_target_initiator: a scripted box responder plus a protocol-level model
// predicting pulse groups, total duration and response for each command.
module tb_post_target_initiator;
    localparam int PWID  = 24;
    localparam int PGAP  = 24;
    localparam int BRK   = 1200;
    localparam logic [1:0] OP_SYNC = 2'b00;
    localparam logic [1:0] OP_OUT  = 2'b01;
    localparam logic [1:0] OP_IN   = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic       clk;
    logic       reset_in_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ok;
    logic [7:0] rsp_data;
    logic       testreq;
    logic       testack;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    bit ack_q[$];
    int exp_groups[$];
    int obs_groups[$];
    int bad_width;
    int bad_gap;
    int hi_run, lo_run, grp_pulses;
    logic prev_req;

    post_target_initiator dut (
        .fpga_clock_48mhz (clk),
        .reset_in_n       (reset_in_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_data         (cmd_data),
        .rsp_valid        (rsp_valid),
        .rsp_ok           (rsp_ok),
        .rsp_data         (rsp_data),
        .testreq          (testreq),
        .testack          (testack),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Box stub and line monitor: answer each rising testreq from the ack plan, measure runs.
    always @(negedge clk) begin
        if (!reset_in_n) begin
            prev_req   = 1'b0;
            hi_run     = 0;
            lo_run     = 0;
            grp_pulses = 0;
            testack    = 1'b0;
        end else begin
            if (testreq) begin
                if (!prev_req) begin
                    if (grp_pulses > 0 && lo_run != PGAP) bad_gap++;
                    if (ack_q.size() > 0) testack = ack_q.pop_front();
                    else testack = 1'($urandom_range(0, 1));
                    hi_run = 1;
                end else begin
                    hi_run++;
                end
            end else begin
                if (prev_req) begin
                    if (hi_run != PWID) bad_width++;
                    grp_pulses++;
                    lo_run = 1;
                end else begin
                    lo_run++;
                end
                if (lo_run == BRK && grp_pulses > 0) begin
                    obs_groups.push_back(grp_pulses);
                    grp_pulses = 0;
                end
            end
            prev_req = testreq;
        end
    end

    function automatic int group_dur(input int n);
        return n * PWID + (n - 1) * PGAP + BRK;
    endfunction

    // Protocol model: appends per-pulse acks and expected groups; returns response and duration.
    task automatic plan(input logic [1:0] op, input logic [7:0] data, input bit st,
                        input logic [7:0] inb, output int exp_ok, output int exp_data,
                        output int exp_dur);
        int n;
        exp_ok = st;
        exp_data = 0;
        exp_dur = 0;
        if (op == OP_SYNC || op == OP_CLR) begin
            n = (op == OP_SYNC) ? 4 : 12;
            for (int i = 0; i < n; i++) ack_q.push_back((i == n - 1) ? st : 1'($urandom_range(0, 1)));
            exp_groups.push_back(n);
            exp_dur = group_dur(n);
        end else if (op == OP_OUT) begin
            for (int i = 0; i < 3; i++) ack_q.push_back((i == 2) ? st : 1'($urandom_range(0, 1)));
            exp_groups.push_back(3);
            exp_dur = group_dur(3);
            if (st) begin
                for (int b = 7; b >= 0; b--) begin
                    n = data[b] ? 1 : 2;
                    for (int i = 0; i < n; i++) ack_q.push_back(1'($urandom_range(0, 1)));
                    exp_groups.push_back(n);
                    exp_dur += group_dur(n);
                end
            end
        end else begin
            for (int i = 0; i < 4; i++) ack_q.push_back((i == 3) ? st : 1'($urandom_range(0, 1)));
            if (st) begin
                for (int b = 7; b >= 0; b--) ack_q.push_back(inb[b]);
                exp_groups.push_back(12);
                exp_dur = group_dur(12);
                exp_data = inb;
            end else begin
                exp_groups.push_back(4);
                exp_dur = group_dur(4);
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] data);
        int w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        cmd_op = op;
        cmd_data = data;
        cmd_valid = 1'b1;
        @(negedge clk);
    endtask

    // Counts cycles from the current negedge until rsp_valid; optional busy-time noise on cmd_*.
    task automatic wait_rsp(input bit noise, output int dur, output int timed_out);
        dur = 0;
        timed_out = 0;
        forever begin
            if (rsp_valid) begin
                if (noise) cmd_valid = 1'b0;
                return;
            end
            if (dur > 20000) begin
                timed_out = 1;
                cmd_valid = 1'b0;
                return;
            end
            dur++;
            if (noise) begin
                cmd_valid = ($urandom_range(0, 39) == 0);
                cmd_op = 2'($urandom_range(0, 3));
                cmd_data = 8'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic compare_groups(input string name);
        int n;
        check({name, "/group_count"}, obs_groups.size(), exp_groups.size());
        n = (obs_groups.size() < exp_groups.size()) ? obs_groups.size() : exp_groups.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s/group%0d", name, i), obs_groups[i], exp_groups[i]);
        check({name, "/pulse_width"}, bad_width, 0);
        check({name, "/pulse_gap"}, bad_gap, 0);
    endtask

    task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] data,
                           input bit st, input logic [7:0] inb, input bit noise);
        int exp_ok, exp_data, exp_dur, dur, to;
        obs_groups.delete();
        exp_groups.delete();
        ack_q.delete();
        bad_width = 0;
        bad_gap = 0;
        plan(op, data, st, inb, exp_ok, exp_data, exp_dur);
        issue(op, data);
        check({name, "/req_rise"}, testreq, 1);
        check({name, "/busy"}, busy, 1);
        cmd_valid = 1'b0;
        wait_rsp(noise, dur, to);
        check({name, "/timeout"}, to, 0);
        check({name, "/rsp_ok"}, rsp_ok, exp_ok);
        check({name, "/rsp_data"}, rsp_data, exp_data);
        check({name, "/duration"}, dur, exp_dur);
        @(negedge clk);
        check({name, "/rsp_pulse"}, rsp_valid, 0);
        check({name, "/ok_hold"}, rsp_ok, exp_ok);
        compare_groups(name);
        $display("[TB] %s op=%0d data=%02h st=%0d -> ok=%0d data=%02h dur=%0d",
                 name, op, data, st, rsp_ok, rsp_data, dur);
    endtask

    initial begin
        int ok1, d1, dur1, ok2, d2, dur2, dur, to, seen;
        int out_ok_left;
        logic [1:0] op;
        bit st;

        reset_in_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        cmd_data = 8'h00;
        bad_width = 0;
        bad_gap = 0;
        repeat (3) @(negedge clk);
        check("reset/testreq", testreq, 0);
        check("reset/cmd_ready", cmd_ready, 1);
        check("reset/busy", busy, 0);
        check("reset/rsp_valid", rsp_valid, 0);
        check("reset/rsp_ok", rsp_ok, 0);
        check("reset/rsp_data", rsp_data, 0);
        reset_in_n = 1'b1;
        @(negedge clk);

        run_cmd("sync", OP_SYNC, 8'h00, 1'b1, 8'h00, 1'b0);
        run_cmd("out_a8", OP_OUT, 8'hA8, 1'b1, 8'h00, 1'b0);
        run_cmd("out_55_full", OP_OUT, 8'h55, 1'b0, 8'h00, 1'b0);
        run_cmd("in_empty", OP_IN, 8'h00, 1'b0, 8'h00, 1'b0);
        run_cmd("in_42", OP_IN, 8'h00, 1'b1, 8'h42, 1'b0);
        run_cmd("in_12", OP_IN, 8'h00, 1'b1, 8'h12, 1'b1);
        run_cmd("in_ff", OP_IN, 8'h00, 1'b1, 8'hFF, 1'b1);
        run_cmd("in_34", OP_IN, 8'h00, 1'b1, 8'h34, 1'b1);
        run_cmd("in_none", OP_IN, 8'h00, 1'b0, 8'h00, 1'b0);
        run_cmd("out_0f", OP_OUT, 8'h0F, 1'b1, 8'h00, 1'b0);

        // Reset mid-OUTPUT while testreq is high
        ack_q.delete();
        exp_groups.delete();
        plan(OP_OUT, 8'hA8, 1'b1, 8'h00, ok1, d1, dur1);
        issue(OP_OUT, 8'hA8);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid/req_before", testreq, 1);
        reset_in_n = 1'b0;
        @(negedge clk);
        check("rst_mid/testreq", testreq, 0);
        seen = rsp_valid;
        repeat (9) begin
            @(negedge clk);
            if (rsp_valid || testreq) seen = 1;
        end
        reset_in_n = 1'b1;
        ack_q.delete();
        @(negedge clk);
        check("rst_mid/no_rsp", seen, 0);
        check("rst_mid/cmd_ready", cmd_ready, 1);
        check("rst_mid/rsp_ok", rsp_ok, 0);
        $display("[TB] rst_mid reset during OUTPUT -> cmd_ready=%0d", cmd_ready);

        // Back-to-back: SYNC then CLEAR with cmd_valid held through the RESP cycle
        obs_groups.delete();
        exp_groups.delete();
        ack_q.delete();
        bad_width = 0;
        bad_gap = 0;
        plan(OP_SYNC, 8'h00, 1'b1, 8'h00, ok1, d1, dur1);
        plan(OP_CLR, 8'h00, 1'b0, 8'h00, ok2, d2, dur2);
        issue(OP_SYNC, 8'h00);
        check("b2b/sync_rise", testreq, 1);
        cmd_op = OP_CLR;
        wait_rsp(1'b0, dur, to);
        check("b2b/sync_timeout", to, 0);
        check("b2b/sync_ok", rsp_ok, ok1);
        check("b2b/sync_dur", dur, dur1);
        @(negedge clk);
        check("b2b/clr_rise", testreq, 1);
        check("b2b/clr_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        wait_rsp(1'b0, dur, to);
        check("b2b/clr_timeout", to, 0);
        check("b2b/clr_ok", rsp_ok, ok2);
        check("b2b/clr_dur", dur, dur2);
        compare_groups("b2b");
        $display("[TB] b2b sync+clear -> ok=%0d dur=%0d", rsp_ok, dur);
        @(negedge clk);

        out_ok_left = 1;
        for (int n = 0; n < 10; n++) begin
            op = 2'($urandom_range(0, 3));
            st = ($urandom_range(0, 3) != 0);
            if (op == OP_OUT && st) begin
                if (out_ok_left == 0) st = 1'b0;
                else out_ok_left--;
            end
            run_cmd($sformatf("rand%0d", n), op, 8'($urandom), st, 8'($urandom), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/post_target_initiator.md
Name: post_target_initiator

Overview:
- Target-side initiator of the POST port protocol; the machine end that post_box_usb responds to.
- Converts byte-level commands into timed testreq pulse groups and samples testack.
- Provides four operations: SYNC (4 pulses), CLEAR (12 pulses), OUTPUT (send byte to box) and INPUT (read byte from box).
- Used on test FPGAs to emulate a target and drive post_box_usb in-system.

Parameters:
PWID_CYCLES, 24, testreq high time per pulse (500 ns at 48 MHz)
PGAP_CYCLES, 24, testreq low time between pulses within a group
BREAK_CYCLES, 1200, testreq low time terminating a group (25 us)
SAMPLE_DELAY, 5, cycles after a pulse's rising edge at which testack is sampled; must be >= 3 and < PWID_CYCLES

Ports:
fpga_clock_48mhz  in  1  sole clock
reset_in_n  in  1  synchronous reset, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready
cmd_op  in  2  00 SYNC, 01 OUTPUT, 10 INPUT, 11 CLEAR
cmd_data  in  8  byte for OUTPUT; ignored otherwise
rsp_valid  out  1  one-cycle pulse, command complete
rsp_ok  out  1  ack sampled high at status point (SYNC/CLEAR: final pulse's sampled ack)
rsp_data  out  8  byte received by INPUT; 0 for other ops or when rsp_ok=0
testreq  out  1  POST request line, true polarity
testack  in  1  POST ack line, true polarity, asynchronous; 2-FF synchronised internally
busy  out  1  inverse of cmd_ready

Behaviour:
- Reset, sampled on the clock edge while reset_in_n=0:
  - testreq=0, cmd_ready=1, rsp_valid=0, rsp_ok=0, rsp_data=0.
  - State goes to IDLE, all counters clear, synchroniser clears.
  - Reset mid-operation aborts with no rsp_valid; testreq is low from the first reset edge.
- Pulse: testreq high for exactly PWID_CYCLES, then low for PGAP_CYCLES if more pulses follow in the group, else low for BREAK_CYCLES.
- Sampling: ack is the synchronised testack captured SAMPLE_DELAY cycles after each rising edge of testreq. The status ack of a group is the value captured on its final pulse.
- FSM states: IDLE, HIGH, GAP, BREAK, RESP. A down-counter timer handles phase timing; pulse_cnt counts pulses in the group; bit_cnt counts data bits.
- Acceptance: command captured on the accept edge. testreq rises on the following cycle. cmd_ready drops on that same following cycle.
- SYNC / CLEAR: 4 or 12 pulses, then a break. rsp_ok = status ack.
- OUTPUT:
  - 3 pulses, then a break.
  - If status ack=0: respond rsp_ok=0; no data sent.
  - Else send 8 bits, MSB first. Bit 1 = 1 pulse + break; bit 0 = 2 pulses + break.
  - Respond rsp_ok=1.
- INPUT:
  - 4 pulses.
  - If status ack=0: break, then respond rsp_ok=0, rsp_data=0.
  - Else, after PGAP_CYCLES, issue 8 more pulses without intervening breaks. On each, shift the captured ack into rsp_data from the LSB, so the first captured bit ends in bit 7.
  - Then break; respond rsp_ok=1.
- RESP:
  - rsp_valid high for exactly one cycle, entered on the cycle after the final break expires.
  - cmd_ready=1 in that same cycle.
  - A command accepted in the RSP cycle starts normally (back-to-back allowed).
  - rsp_ok and rsp_data hold until the next rsp_valid.
- cmd_valid while busy: ignored, no queuing; cmd_op/cmd_data changes have no effect.
- Width rules:
  - timer is wide enough for max(PWID, PGAP, BREAK) - 1.
  - pulse_cnt is 4 bits.
  - bit_cnt is 3 bits; the data phase ends after bit_cnt wraps from 7.
- Total durations: SYNC = 4*PWID + 3*PGAP + BREAK = 1368 cycles. OUTPUT with ack=0 = 3*PWID + 2*PGAP + BREAK = 1320 cycles.

Test Plan:
- Reset held 10 cycles mid-OUTPUT -> testreq low from the first reset edge; no rsp_valid; cmd_ready=1 after release.
- SYNC against post_box_usb, then OUTPUT 0xA8 -> rsp_ok=1; SPI read returns 0xA8. A second OUTPUT 0x55 before the SPI read -> rsp_ok=0.
- INPUT with empty box -> rsp_ok=0, rsp_data=0, total 1368 cycles. Then SPI-load 0x42 and INPUT -> rsp_ok=1, rsp_data=0x42.
- Chained INPUTs of 0x12, 0xFF, 0x34, each SPI-loaded before its command -> rsp_data matches each byte. A following INPUT with nothing loaded -> rsp_ok=0.
- Pulse timing monitor on an OUTPUT of 0x0F (status ack from a stub responder) -> every high phase is 24 cycles, intra-group gap 24, break 1200, pulse counts 3, 2,2,2,2, 1,1,1,1.
- Back-to-back: cmd_valid held high with SYNC then CLEAR -> CLEAR accepted in the RSP cycle; testreq rises the next cycle. cmd_valid pulsed while busy -> ignored.
